// File: rtl/div_pkg.sv
// Shared types and default sizing for the HI/LO divide sequencer.
package div_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 32;
    localparam int unsigned DIV_LATENCY_DEF = 8;
    localparam int unsigned CNT_WIDTH       = $clog2(DIV_LATENCY_DEF + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } div_state_e;

endpackage

// File: rtl/div_rem_calc.sv
// Remainder from dividend, divisor and quotient: rem = a - q*b (truncated).
// Two's-complement low bits give the dividend-signed remainder in both modes.
module div_rem_calc #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] q,
    input  logic         sign,
    output logic [W-1:0] rem
);

    logic [W-1:0] prod_u;
    logic [W-1:0] prod_s;

    always_comb begin
        prod_u = q * b;
        prod_s = $signed(q) * $signed(b);
        rem    = a - (sign ? prod_s : prod_u);
    end

endmodule

// File: rtl/div_hilo_ctrl.sv
// Divide sequencer and HI/LO result stage in front of a combinational divider.
// Optional build macro: DIV_EARLY_OUT_EN (single-cycle x/1 and 0/x divides).
module div_hilo_ctrl
    import div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sign,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    input  logic                    flush,
    input  logic                    mthi,
    input  logic                    mtlo,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_req,
    output logic [DATA_WIDTH-1:0]   div_a,
    output logic [DATA_WIDTH-1:0]   div_b,
    output logic                    div_en,
    output logic                    div_sign,
    input  logic [2*DATA_WIDTH-1:0] div_c,
    output logic [DATA_WIDTH-1:0]   hi,
    output logic [DATA_WIDTH-1:0]   lo,
    output logic                    busy,
    output logic                    stall,
    output logic                    done,
    output logic                    div_by_zero
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DIV_LATENCY + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     a_d, b_d, hi_d, lo_d;
    logic             sign_d, done_d, dbz_d, en_d, busy_d;
    logic             early;
    logic [W-1:0]     quot;
    logic [W-1:0]     rem;
    logic             unused_div_hi;

    // Upper half of the divider result is its own remainder; we derive ours.
    assign quot          = div_c[W-1:0];
    assign unused_div_hi = ^div_c[2*W-1:W];

    assign stall = busy & (start | rd_req | mthi | mtlo);

    div_rem_calc #(.W(W)) u_rem (
        .a    (div_a),
        .b    (div_b),
        .q    (quot),
        .sign (div_sign),
        .rem  (rem)
    );

    always_comb begin
`ifdef DIV_EARLY_OUT_EN
        early = (op_b == W'(1)) || ((op_a == '0) && (op_b != '0));
`else
        early = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = div_a;
        b_d     = div_b;
        sign_d  = div_sign;
        hi_d    = hi;
        lo_d    = lo;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mthi) hi_d = wr_data;
                if (mtlo) lo_d = wr_data;
                if (start && !flush) begin
                    a_d    = op_a;
                    b_d    = op_b;
                    sign_d = sign;
                    // A same-cycle divide result takes priority over mthi/mtlo
                    if (early) begin
                        hi_d   = '0;
                        lo_d   = (op_b == W'(1)) ? op_a : '0;
                        done_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(DIV_LATENCY - 1);
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    en_d   = 1'b1;
                    busy_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    if (div_b != '0) begin
                        lo_d   = quot;
                        hi_d   = rem;
                        done_d = 1'b1;
                    end else begin
                        dbz_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_a       <= '0;
            div_b       <= '0;
            div_sign    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            div_en      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_a       <= a_d;
            div_b       <= b_d;
            div_sign    <= sign_d;
            hi          <= hi_d;
            lo          <= lo_d;
            done        <= done_d;
            div_by_zero <= dbz_d;
            div_en      <= en_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl with a behavioural combinational divider.
module tb_div_hilo_ctrl;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = 8;

    logic           clk, rst, start, sign, flush, mthi, mtlo, rd_req;
    logic [W-1:0]   op_a, op_b, wr_data;
    logic [W-1:0]   div_a, div_b, hi, lo;
    logic           div_en, div_sign, busy, stall, done, div_by_zero;
    logic [2*W-1:0] div_c;

    int n_cmp = 0;
    int n_bad = 0;

    div_hilo_ctrl #(.DATA_WIDTH(W), .DIV_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .sign(sign),
        .op_a(op_a), .op_b(op_b), .flush(flush), .mthi(mthi), .mtlo(mtlo),
        .wr_data(wr_data), .rd_req(rd_req), .div_a(div_a), .div_b(div_b),
        .div_en(div_en), .div_sign(div_sign), .div_c(div_c), .hi(hi), .lo(lo),
        .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference divider: truncating division, MIN/-1 wraps
    always_comb begin
        logic [W-1:0] q, r;
        q = '0;
        r = '0;
        if (div_b != '0) begin
            if (div_sign) begin
                if (div_a == 32'h8000_0000 && div_b == 32'hFFFF_FFFF) begin
                    q = div_a;
                    r = '0;
                end else begin
                    q = $signed(div_a) / $signed(div_b);
                    r = $signed(div_a) % $signed(div_b);
                end
            end else begin
                q = div_a / div_b;
                r = div_a % div_b;
            end
        end
        div_c = {r, q};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full-length divide; samples busy for the LAT cycles after the start edge
    task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                          input logic exp_done, input logic exp_dbz);
        int nb;
        op_a = a; op_b = b; sign = s; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_div_a"}, 64'(div_a), 64'(a));
        nb = 0;
        for (int i = 0; i < int'(LAT); i++) begin
            if (busy) nb++;
            tick();
        end
        check({tag, "_busy_cycles"}, 64'(nb), 64'(LAT));
        check({tag, "_busy_off"}, 64'(busy), 64'(0));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_done"}, 64'(done), 64'(exp_done));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        tick();
        check({tag, "_done_pulse"}, 64'({done, div_by_zero}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int nst;
        rst = 1'b1; start = 1'b0; sign = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        rd_req = 1'b0; op_a = '0; op_b = '0; wr_data = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_state", 64'({hi, lo}), 64'(0));
        check("rst_flags", 64'({busy, done, div_by_zero, div_en, div_sign}), 64'(0));
        check("rst_ops", 64'({div_a, div_b}), 64'(0));

        do_div("udiv", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b1, 1'b0);
        do_div("sdiv", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_div("minneg1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 1'b1, 1'b0);

        // Divide by zero keeps preloaded HI/LO
        mthi = 1'b1; wr_data = 32'h11;
        tick();
        mthi = 1'b0; mtlo = 1'b1; wr_data = 32'h22;
        tick();
        mtlo = 1'b0;
        check("mt_preload", 64'({hi, lo}), {32'h11, 32'h22});
        do_div("dbz", 32'd5, 32'd0, 1'b0, 32'h22, 32'h11, 1'b0, 1'b1);

        // Flush on the 4th WAIT cycle
        op_a = 32'd100; op_b = 32'd7; sign = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("flush_en", 64'(div_en), 64'(1));
        tick(); tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_idle", 64'({busy, div_en, done, div_by_zero}), 64'(0));
        check("flush_hilo", 64'({hi, lo}), {32'h11, 32'h22});
        tick();
        check("flush_nodone", 64'({busy, done, div_by_zero}), 64'(0));

        // Flush together with start in IDLE drops the start
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush_start", 64'({busy, div_en}), 64'(0));

        // Reset in the middle of WAIT
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_hilo", 64'({hi, lo}), 64'(0));
        check("rst_mid_flags", 64'({busy, done, div_by_zero, div_en}), 64'(0));
        check("rst_mid_ops", 64'({div_a, div_b}), 64'(0));

        // Requests while busy: stall each cycle, mtlo and start ignored
        op_a = 32'd100; op_b = 32'd7; sign = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        nst = 0;
        for (int i = 0; i < int'(LAT); i++) begin
            rd_req = 1'b1; mtlo = 1'b1; wr_data = 32'hDEAD; start = 1'b1;
            op_a = 32'd1; op_b = 32'd1;
            #1;
            if (stall) nst++;
            tick();
            rd_req = 1'b0; mtlo = 1'b0; start = 1'b0;
        end
        check("busy_stall_cycles", 64'(nst), 64'(LAT));
        check("busy_lo", 64'(lo), 64'd14);
        check("busy_hi", 64'(hi), 64'd2);
        check("busy_done", 64'(done), 64'(1));
        rd_req = 1'b1;
        #1;
        check("read_nostall", 64'(stall), 64'(0));
        rd_req = 1'b0;
        tick();

        // mtlo with start in the same cycle: applied now, overwritten later
        op_a = 32'd100; op_b = 32'd7; start = 1'b1; mtlo = 1'b1; wr_data = 32'h55;
        tick();
        start = 1'b0; mtlo = 1'b0;
        check("mtlo_start_now", 64'(lo), 64'h55);
        for (int i = 0; i < int'(LAT); i++) tick();
        check("mtlo_start_final", 64'(lo), 64'd14);
        tick();

`ifdef DIV_EARLY_OUT_EN
        op_a = 32'd9; op_b = 32'd1; sign = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("early_lo", 64'(lo), 64'd9);
        check("early_hi", 64'(hi), 64'd0);
        check("early_done", 64'(done), 64'(1));
        check("early_busy", 64'({busy, div_en}), 64'(0));
        tick();
        check("early_done_pulse", 64'(done), 64'(0));
`else
        do_div("by_one", 32'd9, 32'd1, 1'b0, 32'd9, 32'd0, 1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
